mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 23 ++
 rtl/mem_access_unit_resp_fifo.sv | 60 ++++++
 rtl/mem_access_unit.sv | 77 +++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared widths and helpers for the memory access unit.
// Read-credit check used by the request handshake.
package mem_access_unit_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int RESP_DEPTH = 2;
  localparam int CNT_W      = $clog2(RESP_DEPTH + 1);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // Room for one more read: in-flight plus queued stays below depth.
  function automatic logic credit_ok(
    input logic             inflight,
    input logic [CNT_W-1:0] count
  );
    logic [CNT_W:0] occ;
    occ = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    return occ < (CNT_W+1)'(RESP_DEPTH);
  endfunction

endpackage

// File: rtl/mem_access_unit_resp_fifo.sv
// Small in-order response FIFO with occupancy count.
// Storage is unreset; pointers and count clear on reset.
module resp_fifo #(
  parameter  int DATA_W     = 16,
  parameter  int RESP_DEPTH = 2,
  localparam int PTR_W      = (RESP_DEPTH > 1) ?
                              $clog2(RESP_DEPTH) : 1,
  localparam int CNT_W      = $clog2(RESP_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_valid,
  output logic [CNT_W-1:0]  o_count
);

  logic [DATA_W-1:0] r_mem [RESP_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(RESP_DEPTH - 1)) ?
           '0 : p + 1'b1;
  endfunction

  assign w_pop   = i_pop & (r_count != '0);
  assign o_valid = (r_count != '0);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Capture pushed data at the write pointer.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Advance pointers and track occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      unique case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Client-to-dual-port-memory access unit.
// Writes fire immediately; reads return via a credit-limited FIFO.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic              io_req_wr,
  input  logic [ADDR_W-1:0] io_req_addr,
  input  logic [DATA_W-1:0] io_req_wdata,
  output logic              io_resp_valid,
  input  logic              io_resp_ready,
  output logic [DATA_W-1:0] io_resp_rdata,
  output logic [ADDR_W-1:0] io_mem_raddr,
  output logic [ADDR_W-1:0] io_mem_waddr,
  output logic [DATA_W-1:0] io_mem_wdata,
  output logic              io_mem_wen,
  input  logic [DATA_W-1:0] io_mem_rdata,
  input  logic              io_mem_R,
  output logic [15:0]       io_rd_cnt,
  output logic [15:0]       io_wr_cnt
);

  logic             r_inflight;
  logic [15:0]      r_rd_cnt;
  logic [15:0]      r_wr_cnt;
  logic [CNT_W-1:0] w_count;
  logic             w_ready;
  logic             w_acc;
  logic             w_wr_acc;
  logic             w_rd_acc;

  // A same-cycle pop is ignored, so credit is conservative.
  assign w_ready  = reset & io_mem_R &
                    (io_req_wr | credit_ok(r_inflight, w_count));
  assign w_acc    = io_req_valid & w_ready;
  assign w_wr_acc = w_acc & io_req_wr;
  assign w_rd_acc = w_acc & ~io_req_wr;

  assign io_req_ready = w_ready;
  assign io_mem_wen   = w_wr_acc;
  assign io_mem_waddr = io_req_addr;
  assign io_mem_wdata = io_req_wdata;
  assign io_mem_raddr = io_req_addr;
  assign io_rd_cnt    = r_rd_cnt;
  assign io_wr_cnt    = r_wr_cnt;

  // Track the outstanding read and count accepted requests.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_inflight <= 1'b0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
    end else begin
      r_inflight <= w_rd_acc;
      if (w_rd_acc) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_wr_acc) r_wr_cnt <= r_wr_cnt + 1'b1;
    end
  end

  resp_fifo #(
    .DATA_W     (DATA_W),
    .RESP_DEPTH (RESP_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .i_push  (r_inflight),
    .i_wdata (io_mem_rdata),
    .i_pop   (io_resp_ready),
    .o_rdata (io_resp_rdata),
    .o_valid (io_resp_valid),
    .o_count (w_count)
  );

endmodule
